// File: rtl/controle_seguidor_muro.sv
// Wall-following motion controller: synchronised, debounced sensors
// driving a timed turn / removal FSM with registered Moore outputs.
module controle_seguidor_muro #(
  parameter int DEBOUNCE      = 3,
  parameter int TURN_CYCLES   = 8,
  parameter int REMOVE_CYCLES = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clockc2,
  input  logic       reset,
  input  logic       enable,
  input  logic       lado,
  input  logic       head,
  input  logic       left,
  input  logic       right,
  input  logic       under,
  input  logic       barreira,
  output logic       avancar,
  output logic       girar,
  output logic       girar_dir,
  output logic       remover,
  output logic       falha,
  output logic [2:0] estado
);

  localparam int TMAX = (TURN_CYCLES > REMOVE_CYCLES) ?
                        TURN_CYCLES : REMOVE_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] T_TURN = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] T_REM  = TW'(REMOVE_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    PROCURANDO   = 3'b000,
    ACOMPANHANDO = 3'b010,
    REMOVENDO    = 3'b011,
    GIRA         = 3'b100,
    CONTORNA     = 3'b101,
    FALHA        = 3'b110,
    STANDBY      = 3'b111
  } state_e;

  // Sensor bit order: 0 head, 1 left, 2 right, 3 under, 4 barreira
  logic [4:0] raw;
  logic [4:0] s1_q, s2_q;
  logic [4:0] filt;

  assign raw = {barreira, under, right, left, head};

  always_ff @(posedge clockc2 or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_db
    logic [DW-1:0] cnt_q;
    logic          f_q;
    always_ff @(posedge clockc2 or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        f_q   <= 1'b0;
      end else if (s2_q[g] == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == D_LAST) begin
        cnt_q <= '0;
        f_q   <= s2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign filt[g] = f_q;
  end

  logic head_f, under_f, bar_f, side;
  assign head_f  = filt[0];
  assign under_f = filt[3];
  assign bar_f   = filt[4];
  assign side    = lado ? filt[2] : filt[1];

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   tries_q, tries_d;
  logic            restart;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    tries_d = tries_q;
    restart = 1'b0;
    if (!enable) begin
      state_d = STANDBY;
      tries_d = '0;
    end else if (under_f && state_q != FALHA) begin
      state_d = STANDBY;
    end else begin
      case (state_q)
        STANDBY: state_d = PROCURANDO;
        PROCURANDO: begin
          if (bar_f)       state_d = REMOVENDO;
          else if (head_f) state_d = GIRA;
          else if (side)   state_d = ACOMPANHANDO;
        end
        ACOMPANHANDO: begin
          if (bar_f)       state_d = REMOVENDO;
          else if (head_f) state_d = GIRA;
          else if (!side)  state_d = CONTORNA;
        end
        GIRA: begin
          if (bar_f) state_d = REMOVENDO;
          else if (timer_q == T_TURN) begin
            if (head_f) restart = 1'b1;
            else        state_d = ACOMPANHANDO;
          end
        end
        CONTORNA: begin
          if (bar_f)                  state_d = REMOVENDO;
          else if (side)              state_d = ACOMPANHANDO;
          else if (timer_q == T_TURN) state_d = PROCURANDO;
        end
        REMOVENDO: begin
          if (timer_q == T_REM) begin
            if (!bar_f) begin
              state_d = ret_q;
              tries_d = '0;
            end else if (tries_q == R_LAST) begin
              state_d = FALHA;
            end else begin
              tries_d = tries_q + 1'b1;
              restart = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
    // A fresh removal sequence remembers where to resume
    if (state_d == REMOVENDO && state_q != REMOVENDO) begin
      ret_d   = (state_q == PROCURANDO) ? PROCURANDO : ACOMPANHANDO;
      tries_d = '0;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q || restart) timer_d = '0;
    else if (timer_q != {TW{1'b1}})    timer_d = timer_q + 1'b1;
  end

  logic av_q, gi_q, gd_q, rm_q, fa_q;

  always_ff @(posedge clockc2 or negedge reset) begin
    if (!reset) begin
      state_q <= STANDBY;
      ret_q   <= PROCURANDO;
      timer_q <= '0;
      tries_q <= '0;
      av_q    <= 1'b0;
      gi_q    <= 1'b0;
      gd_q    <= 1'b0;
      rm_q    <= 1'b0;
      fa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      av_q    <= (state_d == PROCURANDO) || (state_d == ACOMPANHANDO);
      gi_q    <= (state_d == GIRA) || (state_d == CONTORNA);
      gd_q    <= ((state_d == GIRA) && !lado) ||
                 ((state_d == CONTORNA) && lado);
      rm_q    <= (state_d == REMOVENDO);
      fa_q    <= (state_d == FALHA);
    end
  end

  assign avancar   = av_q;
  assign girar     = gi_q;
  assign girar_dir = gd_q;
  assign remover   = rm_q;
  assign falha     = fa_q;
  assign estado    = state_q;

endmodule

// File: tb/tb_controle_seguidor_muro.sv
// Bench for controle_seguidor_muro: directed scenarios then random
// sensor traffic, all checked cycle by cycle against a reference model.
module tb_controle_seguidor_muro;

  localparam int DEB  = 3;
  localparam int TURN = 8;
  localparam int REM  = 16;
  localparam int MAXR = 3;

  localparam int ST_PR = 0, ST_AC = 2, ST_RE = 3, ST_GI = 4;
  localparam int ST_CO = 5, ST_FA = 6, ST_SB = 7;

  logic clk = 1'b0;
  logic reset, enable, lado, head, left, right, under, barreira;
  logic avancar, girar, girar_dir, remover, falha;
  logic [2:0] estado;

  int n_tests = 0;
  int n_fail  = 0;

  controle_seguidor_muro #(
    .DEBOUNCE(DEB), .TURN_CYCLES(TURN),
    .REMOVE_CYCLES(REM), .MAX_RETRIES(MAXR)
  ) dut (
    .clockc2(clk), .reset(reset), .enable(enable), .lado(lado),
    .head(head), .left(left), .right(right), .under(under),
    .barreira(barreira), .avancar(avancar), .girar(girar),
    .girar_dir(girar_dir), .remover(remover), .falha(falha),
    .estado(estado)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_st, m_ret, m_age, m_tries;
  bit         m_lado;
  logic [4:0] m_f;
  logic [4:0] rq[$];
  logic [4:0] wq[$];

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = ST_SB; m_ret = ST_PR; m_age = 0; m_tries = 0;
    m_lado = 0; m_f = '0;
    rq.delete(); wq.delete();
  endtask

  task automatic model_step();
    int nxt;
    bit restart, side, all_diff;
    logic [4:0] feed;
    if (!reset) begin
      model_reset();
      return;
    end
    side = lado ? m_f[2] : m_f[1];
    nxt = m_st;
    restart = 0;
    if (!enable) begin
      nxt = ST_SB;
      m_tries = 0;
    end else if (m_f[3] && m_st != ST_FA) begin
      nxt = ST_SB;
    end else begin
      case (m_st)
        ST_SB: nxt = ST_PR;
        ST_PR:
          if (m_f[4]) nxt = ST_RE;
          else if (m_f[0]) nxt = ST_GI;
          else if (side) nxt = ST_AC;
        ST_AC:
          if (m_f[4]) nxt = ST_RE;
          else if (m_f[0]) nxt = ST_GI;
          else if (!side) nxt = ST_CO;
        ST_GI:
          if (m_f[4]) nxt = ST_RE;
          else if (m_age == TURN - 1) begin
            if (m_f[0]) restart = 1;
            else nxt = ST_AC;
          end
        ST_CO:
          if (m_f[4]) nxt = ST_RE;
          else if (side) nxt = ST_AC;
          else if (m_age == TURN - 1) nxt = ST_PR;
        ST_RE:
          if (m_age == REM - 1) begin
            if (!m_f[4]) begin
              nxt = m_ret;
              m_tries = 0;
            end else if (m_tries + 1 == MAXR) begin
              nxt = ST_FA;
            end else begin
              m_tries++;
              restart = 1;
            end
          end
        default: ;
      endcase
    end
    if (nxt == ST_RE && m_st != ST_RE) begin
      m_ret = (m_st == ST_PR) ? ST_PR : ST_AC;
      m_tries = 0;
    end
    m_age = (nxt != m_st || restart) ? 0 : m_age + 1;
    m_st = nxt;
    m_lado = lado;
    // Sensors reach the filter two samples late; a filtered bit flips
    // once the last DEB delivered samples all disagree with it.
    feed = (rq.size() >= 2) ? rq[rq.size() - 2] : 5'b0;
    rq.push_back({barreira, under, right, left, head});
    if (rq.size() > 2) void'(rq.pop_front());
    wq.push_back(feed);
    if (wq.size() > DEB) void'(wq.pop_front());
    if (wq.size() == DEB) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1;
        foreach (wq[i]) if (wq[i][b] == m_f[b]) all_diff = 0;
        if (all_diff) m_f[b] = ~m_f[b];
      end
    end
  endtask

  task automatic compare();
    bit gd;
    gd = (m_st == ST_GI) ? !m_lado : (m_st == ST_CO) ? m_lado : 1'b0;
    check("estado", 8'(estado), 8'(m_st));
    check("avancar", 8'(avancar), 8'(m_st == ST_PR || m_st == ST_AC));
    check("girar", 8'(girar), 8'(m_st == ST_GI || m_st == ST_CO));
    check("girar_dir", 8'(girar_dir), 8'(gd));
    check("remover", 8'(remover), 8'(m_st == ST_RE));
    check("falha", 8'(falha), 8'(m_st == ST_FA));
    check("excl", 8'(avancar & girar), 8'(0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_reset(int n);
    reset = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    run(n);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; lado = 1'b0;
    head = 0; left = 0; right = 0; under = 0; barreira = 0;
    model_reset();
    @(negedge clk);
    pulse_reset(2);
    check("rst_estado", 8'(estado), 8'(7));
    enable = 1'b1;
    cycle();
    check("start_proc", 8'(estado), 8'(ST_PR));
    check("start_av", 8'(avancar), 8'(1));
    run(3);

    left = 1; run(2); left = 0; run(8);
    check("pulse_no_acomp", 8'(estado), 8'(ST_PR));
    left = 1; run(8);
    check("held_acomp", 8'(estado), 8'(ST_AC));

    head = 1; run(25);
    check("head_gira", 8'(estado), 8'(ST_GI));
    check("head_dir", 8'(girar_dir), 8'(1));
    head = 0; run(20);
    check("head_back", 8'(estado), 8'(ST_AC));

    barreira = 1; run(60);
    check("bar_falha", 8'(falha), 8'(1));
    enable = 0; run(2);
    check("dis_sb", 8'(estado), 8'(7));
    check("dis_nofalha", 8'(falha), 8'(0));
    barreira = 0; enable = 1; run(12);

    barreira = 1; run(5 + REM + 4); barreira = 0; run(40);
    check("retry_ok", 8'(estado), 8'(ST_AC));

    under = 1; run(8);
    check("under_sb", 8'(estado), 8'(7));
    under = 0; run(10);

    barreira = 1; run(15);
    check("rem_mid", 8'(estado), 8'(ST_RE));
    pulse_reset(2);
    check("rst_mid", 8'(estado), 8'(7));
    barreira = 0;

    lado = 1; right = 1; left = 0; run(10);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) head = ~head;
      if ($urandom_range(0, 9) == 0) left = ~left;
      if ($urandom_range(0, 9) == 0) right = ~right;
      if (barreira) begin
        if ($urandom_range(0, 59) == 0) barreira = 0;
      end else if ($urandom_range(0, 39) == 0) barreira = 1;
      if (under) begin
        if ($urandom_range(0, 7) == 0) under = 0;
      end else if ($urandom_range(0, 119) == 0) under = 1;
      if (enable) begin
        if ($urandom_range(0, 249) == 0) enable = 0;
      end else if ($urandom_range(0, 3) == 0) enable = 1;
      if ($urandom_range(0, 119) == 0) lado = ~lado;
      if ($urandom_range(0, 699) == 0) pulse_reset(1);
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
